// File: rtl/rd_pkg.sv
// ============================================================================
// Module  : rd_pkg
// Brief   : KGP symbol encoding and prefix helpers for the rd_adder_pipe adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rd_pkg;

  typedef logic [1:0] kgp_t;

  // 2'b10 is never produced; carry detection relies on G being all ones.
  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_P = 2'b01;
  localparam kgp_t KGP_G = 2'b11;

  function automatic kgp_t kgp_compose(input kgp_t hi, input kgp_t lo);
    return (hi == KGP_P) ? lo : hi;
  endfunction

  function automatic kgp_t kgp_gen(input logic a, input logic b);
    kgp_t s;
    if (a & b)      s = KGP_G;
    else if (a ^ b) s = KGP_P;
    else            s = KGP_K;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_prefix_level.sv
// ============================================================================
// Module  : rd_prefix_level
// Brief   : One combinational Kogge-Stone level: x[i] = x[i] o x[i-DIST].
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rd_prefix_level #(
  parameter int WIDTH = 64,
  parameter int DIST  = 1
) (
  input  logic [2*WIDTH-1:0] i_sym,
  output logic [2*WIDTH-1:0] o_sym
);
  import rd_pkg::*;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_comb
        assign o_sym[2*i +: 2] = kgp_compose(i_sym[2*i +: 2], i_sym[2*(i-DIST) +: 2]);
      end else begin : g_pass
        assign o_sym[2*i +: 2] = i_sym[2*i +: 2];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rd_adder_pipe.sv
// ============================================================================
// Module  : rd_adder_pipe
// Brief   : Fully pipelined Kogge-Stone adder/subtractor with valid/ready flow.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rd_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  import rd_pkg::*;

  localparam int LEVELS = $clog2(WIDTH);

  logic                 w_advance;
  logic [WIDTH-1:0]     w_b_eff;
  logic                 w_c0;
  kgp_t [WIDTH-1:0]     w_sym0;
  kgp_t [WIDTH-1:0]     w_lvl   [0:LEVELS-1];
  logic [WIDTH-1:0]     w_carry;
  logic [WIDTH-1:0]     w_sum;

  // Stage 0 holds the KGP generation result; stage k holds prefix level k.
  kgp_t [WIDTH-1:0]     r_sym   [0:LEVELS];
  logic [WIDTH-1:0]     r_a     [0:LEVELS];
  logic [WIDTH-1:0]     r_b     [0:LEVELS];
  logic                 r_c0    [0:LEVELS];
  logic [TAG_W-1:0]     r_tag   [0:LEVELS];
  logic                 r_vld   [0:LEVELS];

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_sum;
  logic                 r_out_cout;
  logic                 r_out_ovf;
  logic [TAG_W-1:0]     r_out_tag;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;

  // Carry-in is folded into bit 0 as a G/K symbol, so no separate carry chain.
  always_comb begin
    w_b_eff = in_sub ? ~in_b : in_b;
    w_c0    = in_sub | in_cin;
    w_sym0  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sym0[i] = kgp_gen(in_a[i], w_b_eff[i]);
    end
    w_sym0[0] = kgp_compose(w_sym0[0], w_c0 ? KGP_G : KGP_K);
  end

  genvar k;
  generate
    for (k = 0; k < LEVELS; k++) begin : g_level
      rd_prefix_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_level (
        .i_sym (r_sym[k]),
        .o_sym (w_lvl[k])
      );
    end
  endgenerate

  always_comb begin
    w_carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = (r_sym[LEVELS][i] == KGP_G);
    end
    w_sum = r_a[LEVELS] ^ r_b[LEVELS] ^ {w_carry[WIDTH-2:0], r_c0[LEVELS]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LEVELS; s++) begin
        r_sym[s] <= '0;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_c0[s]  <= 1'b0;
        r_tag[s] <= '0;
        r_vld[s] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      r_sym[0] <= w_sym0;
      r_a[0]   <= in_a;
      r_b[0]   <= w_b_eff;
      r_c0[0]  <= w_c0;
      r_tag[0] <= in_tag;
      // Operands travel with their symbols so the final XOR uses matching copies.
      for (int s = 1; s <= LEVELS; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_sym[s] <= w_lvl[s-1];
        r_a[s]   <= r_a[s-1];
        r_b[s]   <= r_b[s-1];
        r_c0[s]  <= r_c0[s-1];
        r_tag[s] <= r_tag[s-1];
      end
      r_out_valid <= r_vld[LEVELS];
      r_out_sum   <= w_sum;
      r_out_cout  <= w_carry[WIDTH-1];
      r_out_ovf   <= w_carry[WIDTH-1] ^ w_carry[WIDTH-2];
      r_out_tag   <= r_tag[LEVELS];
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_tag   = r_out_tag;

endmodule

`default_nettype wire
